// File: rtl/dtc_stream_driver.sv
// dtc_stream_driver: streams feature vectors into a decision-tree classifier (s_* in, dtc_inp/dtc_outp), packs settled 1-bit results LSB-first into words (m_* out); `define DTC_STREAM_POPCNT_EN adds m_ones
module dtc_stream_driver #(
    parameter int FEAT_W = 11,
    parameter int PACK_W = 8,
    parameter int SETTLE = 1,
    localparam int CW = $clog2(PACK_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [FEAT_W-1:0] s_feat,
    input  logic              s_last,
    output logic [FEAT_W-1:0] dtc_inp,
    input  logic              dtc_outp,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PACK_W-1:0] m_data,
    output logic [CW-1:0]     m_count,
`ifdef DTC_STREAM_POPCNT_EN
    output logic [CW-1:0]     m_ones,
`endif
    output logic              m_last
);
    typedef enum logic [1:0] {IDLE, EVAL, EMIT} state_t;
    state_t state, nxt;
    logic [CW-1:0] idx;
    logic [3:0] cnt;
    logic last_q, sample, done;
    assign s_ready = state == IDLE;
    assign m_valid = state == EMIT;
    assign sample = state == EVAL && cnt == 4'd1;
    assign done = idx == CW'(PACK_W - 1) || last_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state == IDLE ? (s_valid ? EVAL : IDLE) :
              state == EVAL ? (sample ? (done ? EMIT : IDLE) : EVAL) :
              (m_ready ? IDLE : EMIT);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dtc_inp <= '0;
            last_q  <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            m_data  <= '0;
            m_count <= '0;
            m_last  <= 1'b0;
`ifdef DTC_STREAM_POPCNT_EN
            m_ones  <= '0;
`endif
        end else if (state == IDLE && s_valid) begin
            dtc_inp <= s_feat;
            last_q  <= s_last;
            cnt     <= 4'(SETTLE);
        end else if (state == EVAL && !sample) begin
            cnt <= cnt - 4'd1;
        end else if (sample) begin
            m_data <= m_data | (PACK_W'(dtc_outp) << idx);
            idx    <= idx + CW'(1);
`ifdef DTC_STREAM_POPCNT_EN
            m_ones <= m_ones + CW'(dtc_outp);
`endif
            if (done) begin
                m_count <= idx + CW'(1);
                m_last  <= last_q;
            end
        end else if (state == EMIT && m_ready) begin
            m_data <= '0;
            m_last <= 1'b0;
            idx    <= '0;
`ifdef DTC_STREAM_POPCNT_EN
            m_ones <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_dtc_stream_driver.sv
// tb_dtc_stream_driver: directed scoreboard bench for dtc_stream_driver (SETTLE=1 and SETTLE=3 instances)
module tb_dtc_stream_driver;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic [10:0] s_feat = '0;
    logic s_ready, m_valid, m_last, dtc_outp;
    logic [10:0] dtc_inp;
    logic [7:0] m_data;
    logic [3:0] m_count;
    logic s3_valid = 1'b0, s3_last = 1'b1, m3_ready = 1'b0, tog = 1'b0;
    logic [10:0] s3_feat = '0;
    logic s3_ready, m3_valid, m3_last;
    logic [10:0] dtc3_inp;
    logic [7:0] m3_data;
    logic [3:0] m3_count;
`ifdef DTC_STREAM_POPCNT_EN
    logic [3:0] m_ones, m3_ones;
`endif
    assign dtc_outp = dtc_inp[0];
    always @(negedge clk) tog = ~tog;
    dtc_stream_driver #(.FEAT_W(11), .PACK_W(8), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_feat(s_feat),
        .s_last(s_last), .dtc_inp(dtc_inp), .dtc_outp(dtc_outp), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
`ifdef DTC_STREAM_POPCNT_EN
        .m_ones(m_ones),
`endif
        .m_last(m_last));
    dtc_stream_driver #(.FEAT_W(11), .PACK_W(8), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .s_valid(s3_valid), .s_ready(s3_ready), .s_feat(s3_feat),
        .s_last(s3_last), .dtc_inp(dtc3_inp), .dtc_outp(tog), .m_valid(m3_valid),
        .m_ready(m3_ready), .m_data(m3_data), .m_count(m3_count),
`ifdef DTC_STREAM_POPCNT_EN
        .m_ones(m3_ones),
`endif
        .m_last(m3_last));
    int vec_n = 0, err_n = 0;
    typedef struct {logic [7:0] d; logic [3:0] c; logic l; logic [3:0] o;} word_t;
    word_t sb[$];
    word_t got;
    logic [7:0] exp_d = '0;
    int exp_i = 0;
    logic [3:0] exp_o = '0;
    logic [10:0] last_f = '0, f3;
    logic eb;
    int w;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_clear();
        exp_d = '0;
        exp_i = 0;
        exp_o = '0;
    endtask
    task automatic send(input logic r, input logic l, output int k);
        logic [10:0] f = {10'($urandom), r};
        k = 0;
        while (!s_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("s_ready_idle", 32'(s_ready), 1);
        s_valid = 1'b1; s_feat = f; s_last = l;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        chk("dtc_inp_accept", 32'(dtc_inp), 32'(f));
        chk("s_ready_eval", 32'(s_ready), 0);
        last_f = f;
        exp_d[exp_i] = r;
        exp_i++;
        exp_o += 4'(r);
        if (exp_i == 8 || l) begin
            sb.push_back('{exp_d, 4'(exp_i), l, exp_o});
            model_clear();
        end
    endtask
    always @(negedge clk) if (rst_n && m_valid && m_ready) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("m_data", 32'(m_data), 32'(got.d));
            chk("m_count", 32'(m_count), 32'(got.c));
            chk("m_last", 32'(m_last), 32'(got.l));
`ifdef DTC_STREAM_POPCNT_EN
            chk("m_ones", 32'(m_ones), 32'(got.o));
`endif
        end
    end
    initial begin
        #2;
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_dtc_inp", 32'(dtc_inp), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_count", 32'(m_count), 0);
        chk("rst_m_last", 32'(m_last), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        // full word 1,0,1,1,0,0,1,0 -> 4D, s_ready back every 2nd cycle
        foreach (sb[i]) sb.delete(i);
        for (int i = 0; i < 8; i++) begin
            send(1'((8'h4D >> i) & 8'h01), 1'b0, w);
            if (i > 0) chk("s_ready_pulse", 32'(w), 1);
        end
        repeat (2) @(posedge clk); #1;
        chk("post_xfer_valid", 32'(m_valid), 0);
        chk("post_xfer_data", 32'(m_data), 0);
`ifdef DTC_STREAM_POPCNT_EN
        chk("post_xfer_ones", 32'(m_ones), 0);
`endif
        // short batch closed by s_last: 1,1,0 -> 03, count 3, last
        send(1'b1, 1'b0, w);
        send(1'b1, 1'b0, w);
        send(1'b0, 1'b1, w);
        repeat (2) @(posedge clk); #1;
        // stalled full word 0,1,1,0,1,0,0,1 -> 96; extra s_valid must be ignored
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1'((8'h96 >> i) & 8'h01), 1'b0, w);
        @(posedge clk); #1;
        s_valid = 1'b1; s_feat = ~last_f;
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_data", 32'(m_data), 32'h96);
            chk("stall_count", 32'(m_count), 8);
            chk("stall_s_ready", 32'(s_ready), 0);
            chk("stall_dtc_inp", 32'(dtc_inp), 32'(last_f));
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", 32'(m_valid), 0);
        chk("stall_release_s_ready", 32'(s_ready), 1);
        // SETTLE=3: bit captured is dtc_outp at edge T+3, dtc_inp held meanwhile
        for (int i = 0; i < 2; i++) begin
            repeat (i + 1) @(posedge clk); #1;
            f3 = 11'($urandom);
            s3_valid = 1'b1; s3_feat = f3;
            @(posedge clk); #1;
            s3_valid = 1'b0;
            chk("s3_inp_T", 32'(dtc3_inp), 32'(f3));
            @(posedge clk); #1;
            chk("s3_hold1", 32'(dtc3_inp), 32'(f3));
            chk("s3_early1", 32'(m3_valid), 0);
            @(posedge clk); #1;
            chk("s3_hold2", 32'(dtc3_inp), 32'(f3));
            chk("s3_early2", 32'(m3_valid), 0);
            @(negedge clk); #1;
            eb = tog;
            @(posedge clk); #1;
            chk("s3_valid", 32'(m3_valid), 1);
            chk("s3_data", 32'(m3_data), 32'(eb));
            chk("s3_count", 32'(m3_count), 1);
            chk("s3_last", 32'(m3_last), 1);
            chk("s3_hold3", 32'(dtc3_inp), 32'(f3));
            m3_ready = 1'b1;
            @(posedge clk); #1;
            m3_ready = 1'b0;
            chk("s3_xfer_valid", 32'(m3_valid), 0);
            chk("s3_xfer_ready", 32'(s3_ready), 1);
        end
        // reset during EVAL after 5 captured results
        for (int i = 0; i < 5; i++) send(1'((8'h1D >> i) & 8'h01), 1'b0, w);
        @(posedge clk); #1;
        chk("partial_data", 32'(m_data), 32'h1D);
        s_valid = 1'b1; s_feat = 11'h555;
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("pre_rst_eval", 32'(s_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("arst_s_ready", 32'(s_ready), 1);
        chk("arst_m_valid", 32'(m_valid), 0);
        chk("arst_dtc_inp", 32'(dtc_inp), 0);
        chk("arst_m_data", 32'(m_data), 0);
        chk("arst_m_count", 32'(m_count), 0);
        chk("arst_m_last", 32'(m_last), 0);
        model_clear();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(1'((8'hC7 >> i) & 8'h01), 1'b0, w);
        repeat (3) @(posedge clk); #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end
endmodule

// File: doc/dtc_stream_driver.md
Name: dtc_stream_driver

Overview:
- Sequential front/back end for the combinational decision-tree classifier blocks.
- Accepts feature vectors over a valid/ready stream and drives each vector onto the classifier input through a register.
- Waits a fixed settle time, then samples the 1-bit class result.
- Packs results LSB-first into words and returns them over a second valid/ready stream, so a bank of classifiers can be fed from a DMA/FIFO fabric.

Parameters:
- FEAT_W, 11: feature vector width; matches the classifier input width.
- PACK_W, 8: results per output word.
- SETTLE, 1: cycles between a dtc_inp update and sampling dtc_outp. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  feature vector valid.
- s_ready  out  1  driver can accept a vector.
- s_feat  in  FEAT_W  feature vector.
- s_last  in  1  marks the final vector of a batch; forces a flush.
- dtc_inp  out  FEAT_W  registered drive to the classifier input.
- dtc_outp  in  1  classifier result.
- m_valid  out  1  result word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  PACK_W  packed results; result k sits in bit k; unused upper bits are 0.
- m_count  out  $clog2(PACK_W+1)  number of valid results in m_data (1..PACK_W).
- m_last  out  1  word closes a batch.

Behaviour:
- Reset (async assert, sync release): state=IDLE, s_ready=1, m_valid=0, dtc_inp=0, m_data=0, m_count=0, m_last=0, idx=0, settle counter=0.
- A stream transfer occurs on a rising edge where valid&ready=1. Once m_valid is raised, m_data/m_count/m_last hold stable until the transfer.
- FSM, IDLE:
  - s_ready=1.
  - On s_valid: dtc_inp<=s_feat, last_q<=s_last, cnt<=SETTLE, go EVAL.
- FSM, EVAL:
  - s_ready=0.
  - If cnt>1: cnt<=cnt-1.
  - If cnt==1: m_data[idx]<=dtc_outp and idx<=idx+1.
    - If idx+1==PACK_W or last_q: m_count<=idx+1, m_last<=last_q, m_valid<=1, go EMIT.
    - Otherwise go IDLE.
- FSM, EMIT:
  - s_ready=0, m_valid=1.
  - On m_ready: m_valid<=0, m_data<=0, m_last<=0, idx<=0, go IDLE.
  - m_count holds its last value after the transfer; it is don't-care while m_valid=0.
- dtc_inp holds the last accepted vector until the next accept and never changes while in EVAL.
- Latency:
  - Accept at edge T updates dtc_inp at T. dtc_outp is sampled at edge T+SETTLE.
  - For a word that is full or last, m_valid rises at T+SETTLE.
  - Throughput is one vector per SETTLE+1 cycles, plus one cycle per word transfer at minimum.
- Boundaries:
  - s_last on the first vector of a word gives m_count=1, with m_data[PACK_W-1:1]=0.
  - s_last coinciding with the PACK_W-th result gives m_count=PACK_W and m_last=1.
  - m_ready held low stalls indefinitely; no vector is accepted (s_ready=0) and no result is lost.
  - m_ready asserted while m_valid=0 is ignored.
  - s_valid asserted outside IDLE is ignored; the vector is not consumed.
  - rst_n asserted mid-EVAL or mid-EMIT discards the partial word and the pending vector; all outputs return to reset values immediately.
  - The index counter never exceeds PACK_W; wrap to 0 happens only on word transfer.

Optional Feature:
- Macro DTC_STREAM_POPCNT_EN.
- With the macro defined: an extra output m_ones ($clog2(PACK_W+1) bits) equals the number of 1 bits among the valid results of the current word.
  - It is maintained incrementally at each sample, is valid with m_valid, and clears on word transfer and on reset.
- Without the macro: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then 8 back-to-back vectors, SETTLE=1, classifier results 1,0,1,1,0,0,1,0, m_ready=1 → one word m_data=8'h4D, m_count=8, m_last=0; s_ready pulses high every 2nd cycle.
- 3 vectors with s_last on the 3rd, results 1,1,0 → m_data=8'h03, m_count=3, m_last=1; the next word starts at bit 0.
- Full word pending with m_ready held low for 20 cycles → m_valid stays 1, data stable, s_ready=0 throughout; the word transfers on the first m_ready cycle, then s_ready=1 the following cycle.
- SETTLE=3, vector accepted at edge T with dtc_outp toggling each cycle → the bit captured equals the value of dtc_outp at edge T+3; dtc_inp is unchanged from T until the next accept.
- rst_n pulsed low during EVAL after 5 results captured → all outputs at reset values asynchronously; the next batch of 8 results produces a full word starting at bit 0.
- With DTC_STREAM_POPCNT_EN, results 1,0,1,1,0,0,1,0 → m_ones=4 alongside m_data=8'h4D; after the transfer m_ones=0.
